// File: rtl/tick_monitor.sv
// Tick period monitor: measures intervals between tick pulses, locks after LOCK_CNT in-range
// periods, and flags timeouts and faults. Optional min/max statistics under TICK_MONITOR_STATS_EN.
module tick_monitor #(
  parameter int BIT_SZ   = 16,
  parameter int EXPECTED = 501,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              enable,
  input  logic              clear_fault,
  output logic [BIT_SZ-1:0] period,
  output logic              period_valid,
  output logic              locked,
  output logic              fault,
  output logic              miss,
  output logic [BIT_SZ-1:0] min_period,
  output logic [BIT_SZ-1:0] max_period
);

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [BIT_SZ:0] HI_LIM = (BIT_SZ+1)'(EXPECTED + TOL);
  localparam logic [BIT_SZ:0] LO_LIM = (BIT_SZ+1)'((EXPECTED > TOL) ? (EXPECTED - TOL) : 0);
  localparam logic [GW-1:0]   LOCK_GOAL = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t            state_r;
  logic [BIT_SZ-1:0] cnt_r;
  logic [GW-1:0]     good_r;
  logic              missed_r;
  logic [BIT_SZ-1:0] period_r;
  logic              period_valid_r;
  logic              locked_r;
  logic              fault_r;
  logic              miss_r;

  logic [BIT_SZ:0]   meas_s;
  logic              in_range_s;
  logic              miss_hit_s;
  logic              meas_take_s;
  logic [GW-1:0]     good_next_s;

  // Measured period is judged one bit wider so a saturated counter cannot wrap into range
  assign meas_s      = {1'b0, cnt_r} + {{BIT_SZ{1'b0}}, 1'b1};
  assign in_range_s  = (meas_s >= LO_LIM) && (meas_s <= HI_LIM);
  assign good_next_s = good_r + {{(GW-1){1'b0}}, 1'b1};
  assign meas_take_s = enable && !clear_fault && tick && (state_r != ST_IDLE);
  assign miss_hit_s  = ({1'b0, cnt_r} == HI_LIM) && !tick && !missed_r &&
                       ((state_r == ST_MEASURE) || (state_r == ST_LOCKED));

  // Interval counter, lock/fault state machine and registered strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {BIT_SZ{1'b0}};
      good_r         <= {GW{1'b0}};
      missed_r       <= 1'b0;
      period_r       <= {BIT_SZ{1'b0}};
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      fault_r        <= 1'b0;
      miss_r         <= 1'b0;
    end else if (!enable) begin
      period_valid_r <= 1'b0;
      miss_r         <= 1'b0;
    end else begin
      period_valid_r <= 1'b0;
      miss_r         <= 1'b0;
      if (clear_fault) begin
        state_r  <= ST_IDLE;
        cnt_r    <= {BIT_SZ{1'b0}};
        good_r   <= {GW{1'b0}};
        missed_r <= 1'b0;
        locked_r <= 1'b0;
        fault_r  <= 1'b0;
      end else if (tick) begin
        cnt_r    <= {BIT_SZ{1'b0}};
        missed_r <= 1'b0;
        if (meas_take_s) begin
          period_r       <= meas_s[BIT_SZ-1:0];
          period_valid_r <= 1'b1;
        end
        case (state_r)
          ST_IDLE: state_r <= ST_MEASURE;
          ST_MEASURE: begin
            if (!in_range_s) begin
              good_r <= {GW{1'b0}};
            end else if (good_next_s >= LOCK_GOAL) begin
              good_r   <= {GW{1'b0}};
              state_r  <= ST_LOCKED;
              locked_r <= 1'b1;
            end else begin
              good_r <= good_next_s;
            end
          end
          ST_LOCKED: begin
            if (!in_range_s) begin
              state_r  <= ST_FAULT;
              locked_r <= 1'b0;
              fault_r  <= 1'b1;
            end
          end
          ST_FAULT: state_r <= ST_FAULT;
          default: begin
            state_r  <= ST_IDLE;
            locked_r <= 1'b0;
            fault_r  <= 1'b0;
          end
        endcase
      end else begin
        if (cnt_r != {BIT_SZ{1'b1}}) begin
          cnt_r <= cnt_r + {{(BIT_SZ-1){1'b0}}, 1'b1};
        end
        if (miss_hit_s) begin
          miss_r   <= 1'b1;
          missed_r <= 1'b1;
          if (state_r == ST_MEASURE) begin
            good_r <= {GW{1'b0}};
          end else begin
            state_r  <= ST_FAULT;
            locked_r <= 1'b0;
            fault_r  <= 1'b1;
          end
        end
      end
    end
  end

  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign locked       = locked_r;
  assign fault        = fault_r;
  assign miss         = miss_r;

`ifdef TICK_MONITOR_STATS_EN
  logic [BIT_SZ-1:0] min_r;
  logic [BIT_SZ-1:0] max_r;
  logic              seen_r;

  // Extremes of all periods since reset or clear_fault; the first period loads both
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_r  <= {BIT_SZ{1'b0}};
      max_r  <= {BIT_SZ{1'b0}};
      seen_r <= 1'b0;
    end else if (enable && clear_fault) begin
      seen_r <= 1'b0;
    end else if (meas_take_s) begin
      seen_r <= 1'b1;
      if (!seen_r || (meas_s[BIT_SZ-1:0] < min_r)) begin
        min_r <= meas_s[BIT_SZ-1:0];
      end
      if (!seen_r || (meas_s[BIT_SZ-1:0] > max_r)) begin
        max_r <= meas_s[BIT_SZ-1:0];
      end
    end else begin
      seen_r <= seen_r;
    end
  end

  assign min_period = min_r;
  assign max_period = max_r;
`else
  assign min_period = {BIT_SZ{1'b0}};
  assign max_period = {BIT_SZ{1'b0}};
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Bench for tick_monitor: directed scenarios plus randomized intervals, checked every cycle
// against an interval-level reference model.
module tb_tick_monitor;

  localparam int EXP  = 501;
  localparam int TOLR = 2;
  localparam int LOCKN = 4;
  localparam int MODE_IDLE = 0, MODE_MEAS = 1, MODE_LOCK = 2, MODE_FAULT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        enable = 1'b0;
  logic        clear_fault = 1'b0;
  logic [15:0] period;
  logic        period_valid, locked, fault, miss;
  logic [15:0] min_period, max_period;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int m_mode, m_elapsed, m_good, m_period, m_min, m_max;
  bit m_missed, m_seen, m_pv, m_miss;

  tick_monitor dut (
    .clock(clock), .reset(reset), .tick(tick), .enable(enable), .clear_fault(clear_fault),
    .period(period), .period_valid(period_valid), .locked(locked), .fault(fault), .miss(miss),
    .min_period(min_period), .max_period(max_period)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_IDLE; m_elapsed = 0; m_good = 0; m_period = 0;
    m_min = 0; m_max = 0; m_missed = 0; m_seen = 0; m_pv = 0; m_miss = 0;
  endtask

  // One enabled clock edge in terms of elapsed cycles since the previous tick
  task automatic model_edge(input bit t, input bit e, input bit c);
    int p;
    bit inr;
    m_pv = 0; m_miss = 0;
    if (!e) return;
    if (c) begin
      m_mode = MODE_IDLE; m_elapsed = 0; m_good = 0; m_missed = 0; m_seen = 0;
      return;
    end
    m_elapsed++;
    if (t) begin
      p = m_elapsed; m_elapsed = 0; m_missed = 0;
      if (m_mode == MODE_IDLE) begin
        m_mode = MODE_MEAS;
        return;
      end
      m_period = p; m_pv = 1;
      if (!m_seen) begin m_min = p; m_max = p; m_seen = 1; end
      else begin
        if (p < m_min) m_min = p;
        if (p > m_max) m_max = p;
      end
      inr = (p >= EXP - TOLR) && (p <= EXP + TOLR);
      if (m_mode == MODE_MEAS) begin
        if (!inr) m_good = 0;
        else begin
          m_good++;
          if (m_good == LOCKN) begin m_mode = MODE_LOCK; m_good = 0; end
        end
      end else if (m_mode == MODE_LOCK && !inr) m_mode = MODE_FAULT;
    end else if ((m_mode == MODE_MEAS || m_mode == MODE_LOCK) && !m_missed &&
                 m_elapsed == EXP + TOLR + 1) begin
      m_miss = 1; m_missed = 1;
      if (m_mode == MODE_MEAS) m_good = 0;
      else m_mode = MODE_FAULT;
    end
  endtask

  task automatic check_all();
    chk("period", int'(period), m_period);
    chk("period_valid", int'(period_valid), int'(m_pv));
    chk("locked", int'(locked), int'(m_mode == MODE_LOCK));
    chk("fault", int'(fault), int'(m_mode == MODE_FAULT));
    chk("miss", int'(miss), int'(m_miss));
`ifdef TICK_MONITOR_STATS_EN
    chk("min_period", int'(min_period), m_min);
    chk("max_period", int'(max_period), m_max);
`else
    chk("min_period", int'(min_period), 0);
    chk("max_period", int'(max_period), 0);
`endif
  endtask

  task automatic step(input bit t, input bit e, input bit c);
    tick = t; enable = e; clear_fault = c;
    @(posedge clock);
    model_edge(t, e, c);
    #1;
    check_all();
    tick = 1'b0; clear_fault = 1'b0;
  endtask

  // n cycles from the previous tick to this one
  task automatic interval(input int n);
    for (int i = 0; i < n - 1; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("reset_period_async", int'(period), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    #1;
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
    enable = 1'b1;
    check_all();

    // nominal ticks: lock the cycle after the 5th tick
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) interval(501);
    chk("not_locked_after_4_ticks", int'(locked), 0);
    interval(501);
    chk("locked_after_5_ticks", int'(locked), 1);
    chk("nominal_period", int'(period), 501);
    interval(501);

    // long interval: miss then fault, then period 510
    interval(510);
    chk("long_period", int'(period), 510);
    chk("fault_after_miss", int'(fault), 1);
    chk("unlocked_after_miss", int'(locked), 0);

    // clear_fault coincident with tick
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clear_no_valid", int'(period_valid), 0);
    chk("clear_fault_low", int'(fault), 0);
    for (int k = 0; k < 5; k++) interval(501);
    chk("relock", int'(locked), 1);

    // good count clears on an out-of-range period
    step(1'b0, 1'b1, 1'b1);
    interval(300);
    interval(501); interval(501); interval(499); interval(504); interval(501);
    interval(501); interval(501);
    chk("no_lock_after_3_good", int'(locked), 0);
    interval(501);
    chk("lock_after_4_good", int'(locked), 1);

    // enable low mid-interval with ticks still pulsing
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step((i % 7) == 0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("freeze_period", int'(period), 501);
    chk("freeze_locked", int'(locked), 1);

    // statistics over 501, 499, 503 then asynchronous reset mid-interval
    step(1'b0, 1'b1, 1'b1);
    interval(100);
    interval(501); interval(499); interval(503);
`ifdef TICK_MONITOR_STATS_EN
    chk("stats_min", int'(min_period), 499);
    chk("stats_max", int'(max_period), 503);
`else
    chk("stats_min_tied", int'(min_period), 0);
    chk("stats_max_tied", int'(max_period), 0);
`endif
    for (int i = 0; i < 250; i++) step(1'b0, 1'b1, 1'b0);
    async_reset();

    // randomized intervals with occasional clears and enable gaps
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      int n;
      n = int'($urandom_range(496, 508));
      if ($urandom_range(0, 15) == 0) step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < n - 1; i++) begin
        if ($urandom_range(0, 99) == 0) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
